// File: rtl/bcd_meter_counter_if.sv
// Bus between the meter's input conditioning, the BCD counter and the display controller.
// The conditioning side is the master; the counter is the slave.
interface bcd_meter_counter_if #(
  parameter int DIGITS = 4
);
  logic                  tick;
  logic                  load;
  logic [4*DIGITS-1:0]   d;
  logic                  add;
  logic [4*DIGITS-1:0]   add_val;
  logic [4*DIGITS-1:0]   q;
  logic                  zero;
  logic                  low;
  logic                  expire;

  modport master (
    output tick, load, d, add, add_val,
    input  q, zero, low, expire
  );

  modport slave (
    input  tick, load, d, add, add_val,
    output q, zero, low, expire
  );
endinterface

// File: rtl/bcd_meter_counter.sv
// N-digit BCD parking-meter down-counter with preset load, saturating add,
// per-tick countdown that stops at zero, and zero/low/expiry flags.
module bcd_meter_counter #(
  parameter int DIGITS     = 4,
  parameter int LOW_THRESH = 200
) (
  input  logic                clk_i,
  input  logic                clr_i,
  bcd_meter_counter_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = (x[4*i +: 4] > 4'd9) ? 4'd9 : x[4*i +: 4];
    return r;
  endfunction

  // One extra BCD position catches the carry out of the top digit exactly.
  function automatic logic [W-1:0] bcd_add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4*(DIGITS+1)-1:0] s;
    logic                    c;
    logic [4:0]              t;
    c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (t > 5'd9) begin
        t = t + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i +: 4] = t[3:0];
    end
    s[4*DIGITS +: 4] = {3'b0, c};
    if (s[4*DIGITS +: 4] != 4'd0) return {DIGITS{4'd9}};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] a);
    logic [W-1:0] r;
    logic         b;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!b)                       r[4*i +: 4] = a[4*i +: 4];
      else if (a[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
      else begin
        r[4*i +: 4] = a[4*i +: 4] - 4'd1;
        b = 1'b0;
      end
    end
    return r;
  endfunction

  // Packed BCD orders the same as its decimal value, so LOW is a plain vector compare.
  localparam logic [W-1:0] LOW_BCD = to_bcd(LOW_THRESH);

  logic [W-1:0] q_q, q_d;
  logic         expire_q, expire_d;
  logic [W-1:0] sum, stepped;

  always_comb begin
    sum      = bus.add ? bcd_add_sat(q_q, clamp_bcd(bus.add_val)) : q_q;
    stepped  = (bus.tick && sum != '0) ? bcd_dec(sum) : sum;
    q_d      = stepped;
    expire_d = bus.tick && (q_q != '0) && (stepped == '0);
    if (bus.load) begin
      q_d      = clamp_bcd(bus.d);
      expire_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q      <= '0;
      expire_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      expire_q <= expire_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.zero   = (q_q == '0);
  assign bus.low    = (q_q < LOW_BCD);
  assign bus.expire = expire_q;

endmodule
